// File: rtl/vrf_ram.sv
// Multi-read-port vector register file RAM with byte-masked writes,
// selectable read-during-write policy and a zero-fill clear sequencer.
module vrf_ram #(
    parameter int          DATA_W         = 32,
    parameter int          ADDR_W         = 8,
    parameter int          NUM_RD         = 2,
    parameter bit          BYPASS         = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] RESET_WORD     = 32'hdead_dead
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      wmask,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     rvalid,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int                NB      = DATA_W / 8;
    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] RST_VAL = DATA_W'(RESET_WORD);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_mem   [DEPTH];
    logic [DATA_W-1:0]   r_rdata [NUM_RD];
    logic [DATA_W-1:0]   w_new_word;
    logic                w_wr, w_rd;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (clr_req) w_next = S_CLEAR;
            S_CLEAR: if (r_cnt == {ADDR_W{1'b1}}) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_CLEAR);
        w_wr = (r_state == S_IDLE) && we;
        w_rd = (r_state == S_IDLE) && re;
    end

    // Counter wraps to 0 naturally on the last clear cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                  r_cnt <= '0;
        else if (r_state == S_CLEAR) r_cnt <= r_cnt + 1'b1;
    end

    // Post-write word: old content with the enabled bytes replaced.
    always_comb begin
        w_new_word = r_mem[waddr];
        for (int b = 0; b < NB; b++)
            if (wmask[b]) w_new_word[8*b +: 8] = wdata[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (busy)      r_mem[r_cnt] <= '0;
        else if (w_wr) r_mem[waddr] <= w_new_word;
    end

    // Without bypass, the nonblocking memory update leaves the old word visible.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int p = 0; p < NUM_RD; p++) r_rdata[p] <= RST_VAL;
            rvalid <= 1'b0;
        end else begin
            rvalid <= w_rd;
            if (w_rd)
                for (int p = 0; p < NUM_RD; p++)
                    r_rdata[p] <= (BYPASS && w_wr && (waddr == raddr[p*ADDR_W +: ADDR_W]))
                                  ? w_new_word : r_mem[raddr[p*ADDR_W +: ADDR_W]];
        end
    end

    always_comb begin
        rdata = '0;
        for (int p = 0; p < NUM_RD; p++) rdata[p*DATA_W +: DATA_W] = r_rdata[p];
    end

endmodule

// File: tb/tb_vrf_ram.sv
// Randomized self-checking bench for vrf_ram: one bypassing and one
// non-bypassing instance share stimulus and are compared to a word-array model.
module tb_vrf_ram;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        we = 1'b0, re = 1'b0, clr_req = 1'b0;
    logic [3:0]  wmask = '0;
    logic [7:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [15:0] raddr = '0;
    logic [63:0] rdata1, rdata0;
    logic        rvalid1, rvalid0, busy1, busy0;

    always #5 clk = ~clk;

    vrf_ram #(.BYPASS(1'b1)) u_byp (
        .clk(clk), .nrst(nrst), .we(we), .wmask(wmask), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .clr_req(clr_req), .busy(busy1)
    );

    vrf_ram #(.BYPASS(1'b0)) u_old (
        .clk(clk), .nrst(nrst), .we(we), .wmask(wmask), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .clr_req(clr_req), .busy(busy0)
    );

    int          n_chk = 0, n_err = 0;
    logic [31:0] m_mem [256];
    logic [31:0] m_rd1 [2];
    logic [31:0] m_rd0 [2];
    logic        m_rv, m_busy;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic m_reset();
        for (int p = 0; p < 2; p++) begin m_rd1[p] = 32'hdead_dead; m_rd0[p] = 32'hdead_dead; end
        m_rv = 1'b0; m_busy = 1'b1; m_cnt = 0;
    endtask

    task automatic compare();
        chk("busy_b", {31'd0, busy1}, {31'd0, m_busy});
        chk("busy_o", {31'd0, busy0}, {31'd0, m_busy});
        chk("rvalid_b", {31'd0, rvalid1}, {31'd0, m_rv});
        chk("rvalid_o", {31'd0, rvalid0}, {31'd0, m_rv});
        for (int p = 0; p < 2; p++) begin
            chk("rdata_b", rdata1[32*p +: 32], m_rd1[p]);
            chk("rdata_o", rdata0[32*p +: 32], m_rd0[p]);
        end
    endtask

    task automatic tick();
        logic [7:0] a;
        @(posedge clk);
        if (!nrst) m_reset();
        else if (m_busy) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == 256) begin m_cnt = 0; m_busy = 1'b0; end
            m_rv = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                a = raddr[8*p +: 8];
                if (re) begin
                    m_rd0[p] = m_mem[a];
                    m_rd1[p] = (we && a == waddr) ? merge(m_mem[a], wdata, wmask) : m_mem[a];
                end
            end
            m_rv = re;
            if (we) m_mem[waddr] = merge(m_mem[waddr], wdata, wmask);
            if (clr_req) m_busy = 1'b1;
        end
        #1;
        compare();
    endtask

    task automatic idle_in();
        we = 1'b0; re = 1'b0; clr_req = 1'b0; wmask = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        we = 1'b1; waddr = a; wdata = d; wmask = m; re = 1'b0;
        tick();
        idle_in();
    endtask

    task automatic rd(input logic [7:0] a0, input logic [7:0] a1);
        re = 1'b1; raddr = {a1, a0}; we = 1'b0;
        tick();
        idle_in();
    endtask

    // Counts busy-high samples from now on; the clear must last exactly 256.
    task automatic busy_len(input string tag);
        int n;
        n = 0;
        while (busy1 && n < 300) begin
            n++;
            we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
            waddr = 8'($urandom); wdata = $urandom; wmask = 4'($urandom);
            raddr = 16'($urandom);
            tick();
        end
        idle_in();
        chk(tag, n, 256);
    endtask

    task automatic sweep_zero();
        for (int a = 0; a < 128; a++) begin
            rd(8'(a), 8'(a + 128));
            chk("sweep_lo", rdata1[31:0], 32'h0);
            chk("sweep_hi", rdata0[63:32], 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        idle_in();
        #2 nrst = 1'b0;
        #1;
        m_reset();
        compare();
        chk("rst_word", rdata1[63:32], 32'hdead_dead);
        tick(); tick();
        nrst = 1'b1;
        busy_len("busy_after_reset");

        rd(8'h00, 8'hff);
        chk("rd_0x00", rdata1[31:0], 32'h0);
        chk("rd_0xff", rdata1[63:32], 32'h0);
        chk("rvalid_rd", {31'd0, rvalid1}, 32'd1);

        wr(8'h10, 32'hAABBCCDD, 4'b1111);
        wr(8'h10, 32'h11223344, 4'b0101);
        wr(8'h10, 32'hFFFFFFFF, 4'b0000);
        rd(8'h10, 8'h10);
        chk("masked", rdata1[31:0], 32'hAA22CC44);

        we = 1'b1; waddr = 8'h20; wdata = 32'h12345678; wmask = 4'hf;
        re = 1'b1; raddr = {8'h20, 8'h20};
        tick();
        idle_in();
        chk("rdw_byp_p0", rdata1[31:0], 32'h12345678);
        chk("rdw_byp_p1", rdata1[63:32], 32'h12345678);
        chk("rdw_old_p0", rdata0[31:0], 32'h0);
        chk("rdw_old_p1", rdata0[63:32], 32'h0);
        rd(8'h20, 8'h20);
        chk("after_wr_old", rdata0[31:0], 32'h12345678);

        rd(8'h10, 8'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold", rdata1[31:0], 32'hAA22CC44);
            chk("hold_rvalid", {31'd0, rvalid1}, 32'd0);
        end

        for (int i = 0; i < 1500; i++) begin
            we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
            waddr = 8'($urandom_range(0, 15)); wdata = $urandom; wmask = 4'($urandom);
            raddr = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
            clr_req = ($urandom_range(0, 399) == 0);
            tick();
        end
        idle_in();
        for (int i = 0; i < 300 && m_busy; i++) tick();

        for (int i = 0; i < 8; i++) wr(8'(i * 32), $urandom, 4'hf);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_len("busy_after_req");
        sweep_zero();

        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("cnt_at_abort", m_cnt, 100);
        nrst = 1'b0;
        #1;
        m_reset();
        compare();
        tick(); tick();
        nrst = 1'b1;
        busy_len("busy_after_abort");
        sweep_zero();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vrf_ram.md
# vrf_ram

Parametrised multi-read-port register-file RAM for the vector register file, replacing the fixed 256x32, two-read-port storage. It adds:
- a configurable number of read ports;
- per-byte write masking;
- a selectable read-during-write policy;
- a hardware clear sequencer that zero-fills the array after reset or on request.

It sits between the vector register decode/issue stage and the vector lanes. It is the sole storage for vector register elements.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of 8.
- ADDR_W, 8: address width; DEPTH = 2**ADDR_W words.
- NUM_RD, 2: number of independent read ports, 1..4.
- BYPASS, 1: read-during-write policy. 1 returns new data; 0 returns old data.
- CLEAR_ON_RESET, 1: when 1, a zero-fill runs automatically after reset release.
- RESET_WORD, 32'hdead_dead: reset/idle value of every read port, zero-extended to DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- nrst  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- wmask  in  DATA_W/8  byte write enable; bit i covers wdata[8i+7:8i].
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re  in  1  read enable, shared by all read ports.
- raddr  in  NUM_RD*ADDR_W  read addresses; port p uses slice [p*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  registered read data; port p uses slice [p*DATA_W +: DATA_W].
- rvalid  out  1  rdata was updated by a read in the previous cycle.
- clr_req  in  1  single-cycle pulse that requests a zero-fill of the whole array.
- busy  out  1  clear sequencer active; external accesses are ignored.

## Operation
- Reset (nrst low, asynchronous):
  - every rdata port = RESET_WORD; rvalid = 0;
  - clear counter = 0;
  - state = CLEAR if CLEAR_ON_RESET, else IDLE;
  - busy = 1 if CLEAR_ON_RESET, else 0.
- Memory contents are not reset by nrst; only the clear sequencer zeroes them.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR: clr_req = 1 while in IDLE.
  - CLEAR -> IDLE: after writing address DEPTH-1.
  - clr_req while in CLEAR is ignored.
- CLEAR behaviour:
  - each cycle, mem[cnt] <= 0 and cnt <= cnt + 1;
  - exactly DEPTH cycles; cnt wraps to 0 on exit;
  - we and re are ignored; rdata holds; rvalid = 0;
  - busy = 1 for the whole state, and is registered (high in the cycle after the clr_req edge).
- Write, in IDLE with we = 1:
  - for each i with wmask[i] = 1, mem[waddr] byte i <= wdata byte i; other bytes keep their value;
  - wmask = 0 with we = 1 is a legal no-op.
- Read, in IDLE with re = 1:
  - for every port p, rdata[p] <= mem[raddr[p]];
  - rvalid <= 1.
- No read (re = 0, or in CLEAR): rdata holds its previous value; rvalid <= 0.
- Same-cycle read and write to the same address:
  - BYPASS = 1: rdata[p] = merge of old word and masked wdata bytes, i.e. the post-write content;
  - BYPASS = 0: rdata[p] = the pre-write word.
- Multiple ports may read the same address in the same cycle; each returns identical data.
- Ports reading other addresses are unaffected by the write.

## Timing
- Read latency is 1 cycle: address presented at edge N gives data and rvalid at edge N+1.
- Write takes effect at the clock edge. A read issued in the next cycle returns the new data under either BYPASS setting.
- Read and write can both be issued in the same cycle; throughput is one write plus NUM_RD reads per cycle.
- Clear duration:
  - after reset release, busy stays high for DEPTH cycles (256 at default);
  - after clr_req, busy is high for DEPTH cycles, starting the cycle after the request.
- Reset asserted mid-clear aborts the clear. If CLEAR_ON_RESET = 1, the clear restarts from address 0 after release.
- Issuers must hold off requests while busy = 1. Requests in that window are dropped, not queued.

## Test plan
- Reset/clear: assert nrst = 0, then release with CLEAR_ON_RESET = 1 -> rdata = 32'hdead_dead and busy = 1 for 256 cycles. Then read addr 0x00 and 0xff -> 0, with rvalid = 1 one cycle after re.
- Masked write: write 0xAABBCCDD to 0x10 with wmask = 4'b1111, then 0x11223344 with wmask = 4'b0101 -> read of 0x10 returns 0xAA22CC44.
- Read-during-write, same address: write 0x12345678 to 0x20 (old value 0) while reading 0x20 on both ports -> BYPASS = 1 gives 0x12345678 on both ports; BYPASS = 0 gives 0.
- Hold/rvalid: read 0x10 once, then re = 0 for 3 cycles -> rdata stays 0xAA22CC44 and rvalid = 0 in those cycles.
- Clear request mid-traffic: after writes, pulse clr_req, then issue we/re during busy -> those accesses are dropped, busy = 1 for 256 cycles, all addresses read 0 afterwards.
- Reset mid-clear: assert nrst at cnt = 100 -> outputs go to reset values immediately. After release the clear restarts, and busy lasts the full 256 cycles.
